// File: rtl/alu_pkg.sv
// Shared ALU definitions: rotate-sequencer state encoding and rotate direction codes.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/SHIFTER_UNIT_rotate.sv
// Single-position rotate unit: S3=1 rotates right (bit i <- bit i+1), S3=0 rotates left.
module SHIFTER_UNIT_rotate #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic             S3,
  output logic [WIDTH-1:0] C
);

  always_comb begin
    if (S3) begin
      C = {A[0], A[WIDTH-1:1]};
    end else begin
      C = {A[WIDTH-2:0], A[WIDTH-1]};
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-step rotate controller: accepts an operand and amount, applies one single-bit rotate
// per cycle through the shifter unit, then holds the result until the consumer takes it.
module rotate_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [CNT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             busy,
  output logic [7:0]       op_count
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [7:0]       op_count_q, op_count_d;
  logic [WIDTH-1:0] rot_c;

  SHIFTER_UNIT_rotate #(.WIDTH(WIDTH)) u_rot (
    .A (data_q),
    .S3(dir_q),
    .C (rot_c)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    count_d    = count_q;
    dir_d      = dir_q;
    op_count_d = op_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_a;
          dir_d   = in_dir;
          count_d = in_amt;
          state_d = (in_amt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        data_d  = rot_c;
        count_d = count_q - CNT_W'(1);
        // Last rotate is taken on the same edge that enters DONE.
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      count_q    <= '0;
      dir_q      <= DIR_LEFT;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    out_c     = (state_q == ST_DONE) ? data_q : '0;
    op_count  = op_count_q;
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: latency, hold/backpressure, reset abort, counter wrap.
module tb_rotate_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic       busy;
  logic [7:0] op_count;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_ops = 8'd0;

  rotate_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_amt   (in_amt),
    .in_dir   (in_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Right by k is left by 8-k; the model only ever rotates left.
  function automatic logic [7:0] rot_ref(input logic [7:0] a, input int amt, input logic dir);
    logic [7:0] r;
    int k;
    r = a;
    k = dir ? ((8 - amt) % 8) : amt;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic accept(input logic [7:0] a, input logic [2:0] amt, input logic dir);
    in_a     = a;
    in_amt   = amt;
    in_dir   = dir;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_ops = exp_ops + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors += 5;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    if (out_c !== 8'h00) begin
      miscompares++; $display("FAIL reset_out_c got %h want 00", out_c);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", busy);
    end
    if (op_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_op_count got %0d want 0", op_count);
    end
  endtask

  task automatic test_right_one();
    int lat;
    accept(8'h81, 3'd1, 1'b1);
    wait_valid(lat);
    vectors += 3;
    if (lat != 2) begin
      miscompares++; $display("FAIL r1_latency got %0d want 2", lat);
    end
    if (out_c !== 8'hC0) begin
      miscompares++; $display("FAIL r1_out_c got %h want c0", out_c);
    end
    release_result();
    if (op_count !== exp_ops) begin
      miscompares++; $display("FAIL r1_op_count got %0d want %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_left_three();
    int lat;
    logic busy_ok;
    busy_ok = 1'b1;
    accept(8'h01, 3'd3, 1'b0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    vectors += 4;
    if (lat != 4) begin
      miscompares++; $display("FAIL l3_latency got %0d want 4", lat);
    end
    if (out_c !== 8'h08) begin
      miscompares++; $display("FAIL l3_out_c got %h want 08", out_c);
    end
    if (busy_ok !== 1'b1) begin
      miscompares++; $display("FAIL l3_busy_throughout got %b want 1", busy_ok);
    end
    release_result();
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL l3_busy_after got %b want 0", busy);
    end
  endtask

  task automatic test_zero_amount();
    int lat;
    // out_ready in IDLE must not count a transaction.
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    vectors++;
    if (op_count !== exp_ops) begin
      miscompares++; $display("FAIL idle_out_ready op_count got %0d want %0d", op_count, exp_ops);
    end
    accept(8'h5A, 3'd0, 1'b0);
    wait_valid(lat);
    vectors += 2;
    if (lat != 1) begin
      miscompares++; $display("FAIL z_latency got %0d want 1", lat);
    end
    if (out_c !== 8'h5A) begin
      miscompares++; $display("FAIL z_out_c got %h want 5a", out_c);
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    logic [7:0] ops_before;
    accept(8'h01, 3'd7, 1'b1);
    wait_valid(lat);
    vectors += 2;
    if (lat != 8) begin
      miscompares++; $display("FAIL hold_latency got %0d want 8", lat);
    end
    if (out_c !== 8'h02) begin
      miscompares++; $display("FAIL hold_out_c got %h want 02", out_c);
    end
    ops_before = exp_ops;
    for (int i = 0; i < 5; i++) begin
      in_a     = 8'hF0 ^ 8'(i);
      in_amt   = 3'(i);
      in_dir   = i[0];
      in_valid = 1'b1;
      step();
      vectors += 4;
      if (out_valid !== 1'b1) begin
        miscompares++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, out_valid);
      end
      if (out_c !== 8'h02) begin
        miscompares++; $display("FAIL hold_out_c[%0d] got %h want 02", i, out_c);
      end
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready);
      end
      if (op_count !== ops_before) begin
        miscompares++; $display("FAIL hold_op_count[%0d] got %0d want %0d", i, op_count,
                                ops_before);
      end
    end
    in_valid = 1'b0;
    release_result();
    vectors += 3;
    if (op_count !== exp_ops) begin
      miscompares++; $display("FAIL hold_release_op_count got %0d want %0d", op_count, exp_ops);
    end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL hold_release_idle got ready=%b busy=%b want 1/0", in_ready,
                              busy);
    end
    step();
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL hold_no_stale_accept busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    accept(8'hA5, 3'd6, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = 8'd0;
    vectors += 5;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_run_in_ready got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_run_out_valid got %b want 0", out_valid);
    end
    if (op_count !== 8'd0) begin
      miscompares++; $display("FAIL rst_run_op_count got %0d want 0", op_count);
    end
    if (busy !== 1'b0 || out_c !== 8'h00) begin
      miscompares++; $display("FAIL rst_run_busy_c got busy=%b c=%h want 0/00", busy, out_c);
    end
    accept(8'h3C, 3'd2, 1'b0);
    wait_valid(lat);
    if (lat != 3 || out_c !== 8'hF0) begin
      miscompares++; $display("FAIL rst_fresh got lat=%0d c=%h want 3/f0", lat, out_c);
    end
    release_result();
    vectors++;
    if (op_count !== 8'd1) begin
      miscompares++; $display("FAIL rst_fresh_op_count got %0d want 1", op_count);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] a, expc;
    logic [2:0] amt;
    logic dir;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = 8'd0;
    for (int n = 0; n < 256; n++) begin
      a    = 8'($urandom);
      amt  = 3'($urandom_range(0, 7));
      dir  = 1'($urandom_range(0, 1));
      expc = rot_ref(a, int'(amt), dir);
      accept(a, amt, dir);
      wait_valid(lat);
      vectors++;
      if (lat != int'(amt) + 1 || out_c !== expc) begin
        miscompares++;
        $display("FAIL b2b[%0d] a=%h amt=%0d dir=%b got c=%h lat=%0d want c=%h lat=%0d", n, a,
                 amt, dir, out_c, lat, expc, int'(amt) + 1);
      end
      release_result();
      if (n == 254) begin
        vectors++;
        if (op_count !== 8'd255) begin
          miscompares++; $display("FAIL b2b_count255 got %0d want 255", op_count);
        end
      end
    end
    vectors++;
    if (op_count !== 8'd0) begin
      miscompares++; $display("FAIL b2b_wrap got %0d want 0", op_count);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_amt    = 3'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_right_one();
    test_left_three();
    test_zero_amount();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
